// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one digit adder reused LSD-first, decimal carry kept between digits.
// Latency: result valid DIGITS cycles after the accept edge; next accept no sooner than DIGITS+2 cycles.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready is seen at an edge.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [4*DIGITS-1:0]   a_q, a_d;
  logic [4*DIGITS-1:0]   b_q, b_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic                  carry_q, carry_d;
  logic [4*DIGITS-1:0]   sum_q, sum_d;
  logic                  cout_q, cout_d;
  logic                  err_q, err_d;

  // Shared digit datapath signals
  logic [3:0]            ad;
  logic [3:0]            bd;
  logic [4:0]            t;
  logic [3:0]            digit;
  logic                  carry_nxt;
  logic                  digit_bad;

  // Select the current operand digits and run them through the single BCD digit adder
  always_comb begin
    ad = 4'd0;
    bd = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDXW'(k)) begin
        ad = a_q[4*k +: 4];
        bd = b_q[4*k +: 4];
      end
    end
    t         = {1'b0, ad} + {1'b0, bd} + {4'd0, carry_q};
    carry_nxt = (t > 5'd9);
    // +6 correction is taken modulo 16, so 4-bit arithmetic on the low nibble is exact
    digit     = carry_nxt ? (t[3:0] + 4'd6) : t[3:0];
    digit_bad = (ad > 4'd9) | (bd > 4'd9);
  end

  // Next-state and register updates for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          err_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < DIGITS; k++) begin
          if (idx_q == IDXW'(k)) begin
            sum_d[4*k +: 4] = digit;
          end
        end
        err_d   = err_q | digit_bad;
        carry_d = carry_nxt;
        if (idx_q == LAST_IDX) begin
          cout_d  = carry_nxt;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        // Results stay put after the handshake; only a new accept clears them
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  // Handshake outputs decode from state only; no input-to-output combinational path
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl (DIGITS=4 main instance, DIGITS=1 corner instance).
// Directed cases plus a randomized back-to-back stream checked against a decimal reference model.
module tb_bcd_serial_add_ctrl;

  localparam int D = 4;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [4*D-1:0] a;
  logic [4*D-1:0] b;
  logic           cin;
  logic           out_valid;
  logic           out_ready;
  logic [4*D-1:0] sum;
  logic           cout;
  logic           err;

  logic           in_valid1;
  logic           in_ready1;
  logic [3:0]     a1;
  logic [3:0]     b1;
  logic           cin1;
  logic           out_valid1;
  logic           out_ready1;
  logic [3:0]     sum1;
  logic           cout1;
  logic           err1;

  int n_checks = 0;
  int n_errors = 0;

  bcd_serial_add_ctrl #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .err(err)
  );

  bcd_serial_add_ctrl #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .err(err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain decimal addition for valid operands; digit-by-digit rule when a digit is >9
  function automatic void ref_add(input logic [4*D-1:0] pa, input logic [4*D-1:0] pb,
                                  input logic pc, output logic [4*D-1:0] s,
                                  output logic co, output logic e);
    int unsigned da, db, tot, lim, x, y, t, c;
    bit bad;
    da = 0; db = 0; lim = 1; bad = 0;
    for (int k = D - 1; k >= 0; k--) begin
      x = 32'(pa[4*k +: 4]);
      y = 32'(pb[4*k +: 4]);
      if (x > 9 || y > 9) bad = 1;
      da  = da * 10 + x;
      db  = db * 10 + y;
      lim = lim * 10;
    end
    s = '0;
    if (!bad) begin
      tot = da + db + 32'(pc);
      co  = (tot >= lim);
      tot = tot % lim;
      for (int k = 0; k < D; k++) begin
        s[4*k +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
    end else begin
      c = 32'(pc);
      for (int k = 0; k < D; k++) begin
        t = 32'(pa[4*k +: 4]) + 32'(pb[4*k +: 4]) + c;
        if (t > 9) begin
          s[4*k +: 4] = 4'((t + 6) % 16);
          c = 1;
        end else begin
          s[4*k +: 4] = 4'(t);
          c = 0;
        end
      end
      co = c[0];
    end
    e = bad;
  endfunction

  function automatic logic [4*D-1:0] rand_bcd(input bit allow_bad);
    logic [4*D-1:0] v;
    for (int k = 0; k < D; k++) begin
      if (allow_bad && $urandom_range(0, 7) == 0) v[4*k +: 4] = 4'($urandom_range(10, 15));
      else v[4*k +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  // Waits for in_ready, presents one operand set and returns 1ns after the accept edge
  task automatic start_op(input string tag, input logic [4*D-1:0] pa, input logic [4*D-1:0] pb,
                          input logic pc);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = pa; b = pb; cin = pc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits for the result, checks latency/values, then completes the output handshake
  task automatic finish_op(input string tag, input logic [4*D-1:0] es, input logic ec,
                           input logic ee, input bit chk_lat);
    int n;
    bit rdy_seen;
    n = 0; rdy_seen = 0;
    while (!out_valid && n < 50) begin
      if (in_ready) rdy_seen = 1;
      @(posedge clk); #1; n++;
    end
    if (in_ready) rdy_seen = 1;
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    if (chk_lat) begin
      check({tag, "_latency"}, 32'(n), 32'(D));
      check({tag, "_in_ready_busy"}, 32'(rdy_seen), 32'd0);
    end
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_err"}, 32'(err), 32'(ee));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_back_idle"}, {30'd0, in_ready, out_valid}, 32'h2);
  endtask

  logic [4*D-1:0] q_sum[$];
  logic           q_cout[$];
  logic           q_err[$];

  initial begin
    logic [4*D-1:0] ra, rb, es;
    logic           rc, ec, ee;
    int             cyc, last_acc, n_acc, n_done, n_ops, n_seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_handshake", {30'd0, in_ready, out_valid}, 32'h2);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_flags", {30'd0, cout, err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic add, latency and busy in_ready
    start_op("t1", 16'h1234, 16'h5678, 1'b0);
    finish_op("t1", 16'h6912, 1'b0, 1'b0, 1);

    // Carry rippling through all digits, then carry-in alone
    start_op("t2a", 16'h9999, 16'h0001, 1'b0);
    finish_op("t2a", 16'h0000, 1'b1, 1'b0, 1);
    start_op("t2b", 16'h0000, 16'h0000, 1'b1);
    finish_op("t2b", 16'h0001, 1'b0, 1'b0, 1);

    // Backpressure in DONE with ignored in_valid pulses
    start_op("t3", 16'h0500, 16'h0500, 1'b0);
    n_seen = 0;
    while (!out_valid && n_seen < 50) begin
      @(posedge clk); #1; n_seen++;
    end
    for (int i = 0; i < 3; i++) begin
      a = 16'h1111; b = 16'h2222; cin = 1'b0;
      in_valid = (i != 1);
      @(posedge clk); #1;
      check("t3_hold_handshake", {30'd0, in_ready, out_valid}, 32'h1);
      check("t3_hold_sum", 32'(sum), 32'h1000);
      check("t3_hold_cout", 32'(cout), 32'd0);
    end
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("t3_idle_after_ack", {30'd0, in_ready, out_valid}, 32'h2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t3_new_accepted", 32'(in_ready), 32'd0);
    finish_op("t3n", 16'h3333, 1'b0, 1'b0, 0);

    // Invalid digit sets err, next valid operand clears it
    start_op("t4a", 16'h00A0, 16'h0000, 1'b0);
    finish_op("t4a", 16'h0100, 1'b0, 1'b1, 1);
    start_op("t4b", 16'h0042, 16'h0013, 1'b0);
    finish_op("t4b", 16'h0055, 1'b0, 1'b0, 1);

    // Reset two cycles into RUN
    start_op("t5", 16'h1234, 16'h1111, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_handshake", {30'd0, in_ready, out_valid}, 32'h2);
    check("t5_sum", 32'(sum), 32'd0);
    check("t5_flags", {30'd0, cout, err}, 32'd0);
    n_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) n_seen++;
    end
    check("t5_no_spurious", 32'(n_seen), 32'd0);

    // Back-to-back randomized stream, first op is the all-nines case
    n_ops = 24; n_acc = 0; n_done = 0; last_acc = -1;
    a = 16'h9999; b = 16'h9999; cin = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    for (cyc = 0; cyc < 1000 && n_done < n_ops; cyc++) begin
      bit acc_now;
      acc_now = 0;
      if (in_ready && in_valid) begin
        ref_add(a, b, cin, es, ec, ee);
        q_sum.push_back(es); q_cout.push_back(ec); q_err.push_back(ee);
        if (last_acc >= 0) check("t6_spacing", 32'(cyc - last_acc), 32'(D + 2));
        last_acc = cyc;
        n_acc++;
        acc_now = 1;
      end
      if (out_valid) begin
        if (q_sum.size() == 0) begin
          check("t6_unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          check("t6_sum", 32'(sum), 32'(q_sum.pop_front()));
          check("t6_cout", 32'(cout), 32'(q_cout.pop_front()));
          check("t6_err", 32'(err), 32'(q_err.pop_front()));
        end
        n_done++;
      end
      @(posedge clk); #1;
      if (acc_now) begin
        if (n_acc >= n_ops) begin
          in_valid = 1'b0;
        end else begin
          ra = rand_bcd(n_acc > 4);
          rb = rand_bcd(n_acc > 4);
          rc = 1'($urandom_range(0, 1));
          a = ra; b = rb; cin = rc;
        end
      end
    end
    check("t6_completed", 32'(n_done), 32'(n_ops));
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;

    // Single-digit instance: RUN is exactly one cycle
    a1 = 4'd5; b1 = 4'd7; cin1 = 1'b0; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    check("d1_run", {30'd0, in_ready1, out_valid1}, 32'h0);
    @(posedge clk); #1;
    check("d1_done", 32'(out_valid1), 32'd1);
    check("d1_sum", 32'(sum1), 32'd2);
    check("d1_flags", {30'd0, cout1, err1}, 32'h2);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check("d1_idle", {30'd0, in_ready1, out_valid1}, 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
Sequencer that adds two multi-digit packed-BCD operands by time-sharing one BCD digit-adder datapath: 4-bit binary add, then +6 correction when the result exceeds 9. It processes one digit per clock, least-significant digit first, and carries between digits in a register. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It replaces a wide parallel BCD adder chain where area matters more than latency.

Parameters:
DIGITS, 4, number of BCD digits per operand (>=1); operand width is 4*DIGITS bits.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand set a, b, cin is valid.
in_ready  output  1  block can accept an operand set.
a  input  4*DIGITS  operand A, packed BCD; digit k is a[4k+3:4k].
b  input  4*DIGITS  operand B, packed BCD.
cin  input  1  carry into digit 0.
out_valid  output  1  sum, cout and err hold a completed result.
out_ready  input  1  consumer accepts the result.
sum  output  4*DIGITS  packed-BCD sum.
cout  output  1  decimal carry out of digit DIGITS-1.
err  output  1  at least one input digit of a or b was >9.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, err=0, digit index=0, carry=0. Operand registers are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid at an edge: capture a, b and cin into internal registers; set idx=0 and carry=cin; clear sum, cout and err; go to RUN.
  - Inputs are ignored when in_valid=0.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, take digits ad=A[idx] and bd=B[idx]; compute t=ad+bd+carry as 5-bit unsigned, range 0..31.
  - If t>9: digit=(t+6) mod 16 and carry_next=1. Otherwise digit=t[3:0] and carry_next=0.
  - Write the result to sum[4*idx+3:4*idx]. Set err |= (ad>9)|(bd>9).
  - If idx==DIGITS-1: cout=carry_next, go to DONE. Otherwise idx++.
- DONE:
  - out_valid=1, in_ready=0.
  - sum, cout and err are held stable while out_ready=0.
  - On out_ready at an edge: go to IDLE. Result registers keep their values until the next accept.
- Latency and throughput:
  - With accept at edge T, out_valid is first high after edge T+DIGITS.
  - Minimum spacing between accepts is DIGITS+2 cycles. in_ready is high only in IDLE; there is no accept in the same cycle as the DONE handshake.
- Invalid digits: the same correction rule is applied (no saturation) and err=1. sum and cout are still fully defined by the rule above.
- sum, cout and err are meaningful only while out_valid=1. sum bits for digits not yet processed read 0 during RUN.
- No combinational path from in_valid or out_ready to any output. All outputs are registered or decoded from state.
- Reset during RUN or DONE aborts the operation. The next cycle is IDLE with all reset values. No out_valid is produced for the aborted operation.
- in_valid is held high across RUN and DONE: no effect. The operand is re-sampled only in IDLE.
- DIGITS=1: RUN lasts exactly one cycle.

Test Plan:
1. a=0x1234, b=0x5678, cin=0 -> sum=0x6912, cout=0, err=0; out_valid rises exactly 4 cycles after the accept edge; in_ready=0 throughout.
2. a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1, err=0 (carry ripples through every digit). Then a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
3. Backpressure: hold out_ready=0 for 3 cycles in DONE with a=0x0500, b=0x0500 -> sum=0x1000, cout=0 held stable; in_valid pulses with a new operand are ignored. Then out_ready=1 -> IDLE next cycle, and the new operand is accepted on the following edge.
4. Invalid digit: a=0x00A0, b=0x0000, cin=0 -> sum=0x0100, cout=0, err=1. Then a valid operand set -> err returns to 0.
5. Reset mid-operation: assert rst after 2 RUN cycles -> next cycle in_ready=1, out_valid=0, sum=0, cout=0, err=0; no spurious out_valid appears afterward.
6. Back-to-back stream with in_valid and out_ready held high: accepts are spaced exactly DIGITS+2 cycles apart and every sum matches a decimal reference model. Include the 0x9999+0x9999 cin=1 case -> sum=0x9999, cout=1.
